// File: rtl/dreg_bank.sv
// Dual-read-port register bank with per-entry written flags, write-to-read
// bypass, synchronous clear and registered read data.
module dreg_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         d,
   input  logic [$clog2(DEPTH)-1:0] ra0,
   input  logic [$clog2(DEPTH)-1:0] ra1,
   input  logic                     re0,
   input  logic                     re1,
   output logic [WIDTH-1:0]         q0,
   output logic [WIDTH-1:0]         q1,
   output logic [WIDTH-1:0]         qbar0,
   output logic [WIDTH-1:0]         qbar1,
   output logic                     hit0,
   output logic                     hit1
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0] flag_r;
   logic             wr_en_s;
   logic [WIDTH:0]   rd0_s;
   logic [WIDTH:0]   rd1_s;

   // Effective write strobe: clear wins, out-of-range addresses never match an entry.
   always_comb begin
      wr_en_s = 1'b0;
      if (we && !clr) begin
         wr_en_s = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
               wr_en_s = 1'b1;
            end else begin
               wr_en_s = wr_en_s;
            end
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Storage array and written flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (clr) begin
         flag_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
               mem_r[i]  <= d;
               flag_r[i] <= 1'b1;
            end
         end
      end
   end

   // Read lookup for port 0: {hit, data}; unwritten or out-of-range yields zero.
   always_comb begin
      rd0_s = '0;
      if (clr) begin
         rd0_s = '0;
      end else if (wr_en_s && (ra0 == waddr)) begin
         rd0_s = {1'b1, d};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((ra0 == AW'(i)) && flag_r[i]) begin
               rd0_s = {1'b1, mem_r[i]};
            end else begin
               rd0_s = rd0_s;
            end
         end
      end
   end

   // Read lookup for port 1, identical rules to port 0.
   always_comb begin
      rd1_s = '0;
      if (clr) begin
         rd1_s = '0;
      end else if (wr_en_s && (ra1 == waddr)) begin
         rd1_s = {1'b1, d};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((ra1 == AW'(i)) && flag_r[i]) begin
               rd1_s = {1'b1, mem_r[i]};
            end else begin
               rd1_s = rd1_s;
            end
         end
      end
   end

   // Registered read port 0; holds when not enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0   <= '0;
         hit0 <= 1'b0;
      end else if (re0) begin
         q0   <= rd0_s[WIDTH-1:0];
         hit0 <= rd0_s[WIDTH];
      end
   end

   // Registered read port 1; holds when not enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1   <= '0;
         hit1 <= 1'b0;
      end else if (re1) begin
         q1   <= rd1_s[WIDTH-1:0];
         hit1 <= rd1_s[WIDTH];
      end
   end

   assign qbar0 = ~q0;
   assign qbar1 = ~q1;

endmodule

// File: tb/tb_dreg_bank.sv
// Directed self-checking bench for dreg_bank with WIDTH=8, DEPTH=5.
module tb_dreg_bank;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       we;
   logic [2:0] waddr;
   logic [7:0] d;
   logic [2:0] ra0;
   logic [2:0] ra1;
   logic       re0;
   logic       re1;
   logic [7:0] q0;
   logic [7:0] q1;
   logic [7:0] qbar0;
   logic [7:0] qbar1;
   logic       hit0;
   logic       hit1;

   int checks = 0;
   int errors = 0;

   dreg_bank #(.WIDTH(8), .DEPTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .d(d),
      .ra0(ra0), .ra1(ra1), .re0(re0), .re1(re1),
      .q0(q0), .q1(q1), .qbar0(qbar0), .qbar1(qbar1), .hit0(hit0), .hit1(hit1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; clr = 1'b0; re0 = 1'b0; re1 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; we = 1'b0; waddr = 3'd0; d = 8'h00;
      ra0 = 3'd0; ra1 = 3'd0; re0 = 1'b0; re1 = 1'b0;
      #3;
      chk("rst_q0", q0, 8'h00);
      chk("rst_qbar0", qbar0, 8'hFF);
      chk("rst_hit0", {7'd0, hit0}, 8'h00);
      chk("rst_q1", q1, 8'h00);
      chk("rst_qbar1", qbar1, 8'hFF);
      chk("rst_hit1", {7'd0, hit1}, 8'h00);
      #9;
      rst_n = 1'b1;

      // write then read
      we = 1'b1; waddr = 3'd2; d = 8'hA5;
      tick();
      idle(); re0 = 1'b1; ra0 = 3'd2;
      tick();
      chk("wr_rd_q0", q0, 8'hA5);
      chk("wr_rd_qbar0", qbar0, 8'h5A);
      chk("wr_rd_hit0", {7'd0, hit0}, 8'h01);

      // bypass on both ports
      idle(); we = 1'b1; waddr = 3'd3; d = 8'h3C;
      re0 = 1'b1; ra0 = 3'd3; re1 = 1'b1; ra1 = 3'd3;
      tick();
      chk("byp_q0", q0, 8'h3C);
      chk("byp_q1", q1, 8'h3C);
      chk("byp_hit0", {7'd0, hit0}, 8'h01);
      chk("byp_hit1", {7'd0, hit1}, 8'h01);

      // out-of-range write and reads, unwritten entry
      idle(); we = 1'b1; waddr = 3'd5; d = 8'hFF;
      tick();
      idle(); re0 = 1'b1; ra0 = 3'd5; re1 = 1'b1; ra1 = 3'd4;
      tick();
      chk("oor_q0", q0, 8'h00);
      chk("oor_hit0", {7'd0, hit0}, 8'h00);
      chk("unwr_q1", q1, 8'h00);
      chk("unwr_hit1", {7'd0, hit1}, 8'h00);

      // hold while entry 2 is rewritten
      idle(); re0 = 1'b1; ra0 = 3'd2;
      tick();
      chk("hold_pre_q0", q0, 8'hA5);
      idle(); we = 1'b1; waddr = 3'd2; d = 8'h77; ra0 = 3'd2;
      tick();
      chk("hold1_q0", q0, 8'hA5);
      idle();
      tick();
      chk("hold2_q0", q0, 8'hA5);
      chk("hold2_hit0", {7'd0, hit0}, 8'h01);
      tick();
      chk("hold3_q0", q0, 8'hA5);
      re0 = 1'b1;
      tick();
      chk("hold_rd_q0", q0, 8'h77);
      chk("hold_rd_hit0", {7'd0, hit0}, 8'h01);

      // fill, then clear with a competing write and a read-during-clear
      idle();
      for (int a = 0; a < 5; a++) begin
         we = 1'b1; waddr = 3'(a); d = 8'(8'h11 * (a + 1));
         tick();
      end
      idle(); re1 = 1'b1; ra1 = 3'd4;
      tick();
      chk("fill_q1", q1, 8'h55);
      chk("fill_hit1", {7'd0, hit1}, 8'h01);
      idle(); clr = 1'b1; we = 1'b1; waddr = 3'd1; d = 8'h99;
      re0 = 1'b1; ra0 = 3'd1;
      tick();
      chk("rdclr_q0", q0, 8'h00);
      chk("rdclr_hit0", {7'd0, hit0}, 8'h00);
      for (int a = 0; a < 5; a++) begin
         idle(); re0 = 1'b1; ra0 = 3'(a); re1 = 1'b1; ra1 = 3'(4 - a);
         tick();
         chk("clr_q0", q0, 8'h00);
         chk("clr_hit0", {7'd0, hit0}, 8'h00);
         chk("clr_q1", q1, 8'h00);
         chk("clr_hit1", {7'd0, hit1}, 8'h00);
      end

      // independent ports: bypass on port 0, cleared entry on port 1
      idle(); we = 1'b1; waddr = 3'd4; d = 8'hC3;
      re0 = 1'b1; ra0 = 3'd4; re1 = 1'b1; ra1 = 3'd1;
      tick();
      chk("ind_q0", q0, 8'hC3);
      chk("ind_hit0", {7'd0, hit0}, 8'h01);
      chk("ind_q1", q1, 8'h00);
      chk("ind_hit1", {7'd0, hit1}, 8'h00);

      // async reset mid-cycle after writing entry 2 and loading both ports
      idle(); we = 1'b1; waddr = 3'd2; d = 8'hEE;
      re1 = 1'b1; ra1 = 3'd4;
      tick();
      chk("pre_rst_q1", q1, 8'hC3);
      we = 1'b1; waddr = 3'd0; d = 8'h42; re0 = 1'b1; ra0 = 3'd2;
      #4;
      rst_n = 1'b0;
      #1;
      chk("arst_q0", q0, 8'h00);
      chk("arst_qbar0", qbar0, 8'hFF);
      chk("arst_hit0", {7'd0, hit0}, 8'h00);
      chk("arst_q1", q1, 8'h00);
      chk("arst_qbar1", qbar1, 8'hFF);
      chk("arst_hit1", {7'd0, hit1}, 8'h00);
      idle();
      #2;
      rst_n = 1'b1;
      re0 = 1'b1; ra0 = 3'd2; re1 = 1'b1; ra1 = 3'd4;
      tick();
      chk("post_rst_q0", q0, 8'h00);
      chk("post_rst_hit0", {7'd0, hit0}, 8'h00);
      chk("post_rst_q1", q1, 8'h00);
      chk("post_rst_hit1", {7'd0, hit1}, 8'h00);
      idle(); re0 = 1'b1; ra0 = 3'd0;
      tick();
      chk("post_rst_e0", q0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dreg_bank.md
DREG_BANK -- requirements
Module: dreg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (>=2, need not be a power of 2).
REQ-003 SHALL have localparam AW = clog2(DEPTH), the address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clr, input, 1, synchronous clear of all entries.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port waddr, input, AW, write address.
REQ-009 SHALL have port d, input, WIDTH, write data.
REQ-010 SHALL have port ra0 and port ra1, input, AW each, the read addresses for read ports 0 and 1.
REQ-011 SHALL have port re0 and port re1, input, 1 each, the read enables for ports 0 and 1.
REQ-012 SHALL have port q0 and port q1, output, WIDTH each, registered read data.
REQ-013 SHALL have port qbar0 and port qbar1, output, WIDTH each, always the bitwise complement of q0 and q1.
REQ-014 SHALL have port hit0 and port hit1, output, 1 each; high when the last read returned an entry written since the last reset or clear.

Function
REQ-015 SHALL store DEPTH entries of WIDTH bits, each with a written flag.
REQ-016 SHALL write d into entry waddr and set its flag at the rising edge when we=1, clr=0 and waddr<DEPTH.
REQ-017 SHALL ignore writes with waddr>=DEPTH: no state change.
REQ-018 SHALL clear all entries to 0 and all flags to 0 at the rising edge when clr=1.
REQ-019 SHALL let clr win over a same-cycle we: nothing is written.
REQ-020 SHALL give each read port 1-cycle latency: with reN=1 at edge k, qN and hitN reflect the entry at edge k and are valid after edge k.
REQ-021 SHALL hold qN and hitN at their previous values when reN=0.
REQ-022 SHALL return qN=0 and hitN=0 for a read with raN>=DEPTH.
REQ-023 SHALL return qN=0 and hitN=0 for a read of an entry whose flag is 0.
REQ-024 SHALL bypass a read-during-write: if reN=1, we=1, clr=0 and raN==waddr<DEPTH in the same cycle, then qN=d and hitN=1.
REQ-025 SHALL return qN=0 and hitN=0 for a read-during-clear (reN=1 with clr=1), for any address.
REQ-026 SHALL serve both read ports independently, including reads of the same address; each port follows REQ-020 to REQ-025 alone.
REQ-027 SHALL drive qbarN combinationally as ~qN at all times, including during reset.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force all entries and flags to 0, q0=q1=0, qbar0=qbar1=all ones, and hit0=hit1=0, with no clock required.
REQ-029 SHALL discard any write or read in progress when rst_n is asserted mid-operation.
REQ-030 SHALL release reset synchronously in effect: the first state update is at the first rising edge with rst_n=1.

Verification (WIDTH=8, DEPTH=5, AW=3)
REQ-031 SHALL check write then read: we, waddr=2, d=0xA5; next cycle re0=1, ra0=2 -> after that edge q0=0xA5, qbar0=0x5A, hit0=1.
REQ-032 SHALL check bypass and dual read: we, waddr=3, d=0x3C with re0=1, ra0=3 and re1=1, ra1=3 in the same cycle -> q0=q1=0x3C, hit0=hit1=1.
REQ-033 SHALL check boundaries: we, waddr=5, d=0xFF, then read ra0=5 -> q0=0x00, hit0=0; read of an unwritten ra1=4 -> q1=0x00, hit1=0.
REQ-034 SHALL check clear priority: fill entries 0-4 with 0x11-0x55; clr=1 with we, waddr=1, d=0x99 -> reads of all five addresses give q=0x00, hit=0.
REQ-035 SHALL check async reset: mid-stream rst_n=0 between clock edges -> q0=q1=0x00, qbar=0xFF, hit=0 immediately; after release, read ra0=2 -> q0=0x00, hit0=0.
REQ-036 SHALL check hold: re0=0 for 3 cycles while entry 2 is rewritten to 0x77 -> q0 stays at its last value; then re0=1 -> q0=0x77.
